xgmii_frame_fifo: RTL and testbench

//   Single-clock, frame-aware XGMII buffer; successor to the fixed 32b retransmit FIFO.

---
 rtl/xgmii_frame_fifo.sv | 207 ++++++++++++++++++++
 tb/tb_xgmii_frame_fifo.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xgmii_frame_fifo.sv
// Frame-aware XGMII FIFO: strips inter-frame idles on write, inserts idles/underrun fill on read.
// Store-and-forward exposes only committed frames; cut-through error-terminates broken frames.
module xgmii_frame_fifo #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 64,
    parameter bit          STORE_FWD = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           rx_d,
    input  logic [WIDTH/8-1:0]         rx_c,
    input  logic                       rx_vld,
    output logic [WIDTH-1:0]           tx_d,
    output logic [WIDTH/8-1:0]         tx_c,
    input  logic                       tx_rdy,
    output logic [$clog2(DEPTH):0]     level,
    output logic [15:0]                drop_cnt,
    output logic [15:0]                unf_cnt
);

    localparam int unsigned LANES = WIDTH / 8;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned MW    = WIDTH + LANES;

    localparam logic [AW:0]        FULL_LVL = (AW + 1)'(DEPTH);
    localparam logic [WIDTH-1:0]   IDLE_D   = {LANES{8'h07}};
    localparam logic [WIDTH-1:0]   UNF_D    = {LANES{8'hFE}};
    localparam logic [WIDTH-1:0]   ERR_D    = {{(LANES - 2){8'h07}}, 8'hFD, 8'hFE};
    localparam logic [LANES-1:0]   ALL_C    = '1;

    typedef enum logic [1:0] {StIdle, StInFrame, StDiscard} wstate_e;

    logic [MW-1:0] mem [DEPTH];

    wstate_e       wstate_q, wstate_d;
    logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d, cptr_q, cptr_d, level_d;
    logic          err_pend_q, err_pend_d, rd_inframe_q;

    logic          we, drop_inc;
    logic [AW-1:0] waddr;
    logic [MW-1:0] wdata, rd_word;
    logic          is_start, is_term, full, no_space, rewind_ok, err_wr;
    logic          readable, rd_en, rd_start, rd_term;

    function automatic logic has_term(input logic [WIDTH-1:0] d, input logic [LANES-1:0] c);
        logic t;
        t = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (c[i] && d[8*i +: 8] == 8'hFD) t = 1'b1;
        end
        return t;
    endfunction

    always_comb begin
        is_start  = rx_c[0] && (rx_d[7:0] == 8'hFB);
        is_term   = has_term(rx_d, rx_c);
        full      = (level == FULL_LVL);
        no_space  = full || (STORE_FWD && ((wptr_q - cptr_q) == FULL_LVL));
        rewind_ok = ((cptr_q - rptr_q) != FULL_LVL);
        err_wr    = !STORE_FWD && err_pend_q && !full;
        readable  = STORE_FWD ? (rptr_q != cptr_q) : (rptr_q != wptr_q);
        rd_en     = tx_rdy && readable;
        rptr_d    = rptr_q + {{AW{1'b0}}, rd_en};
        rd_word   = mem[rptr_q[AW-1:0]];
        rd_start  = rd_word[WIDTH] && (rd_word[7:0] == 8'hFB);
        rd_term   = has_term(rd_word[WIDTH-1:0], rd_word[MW-1:WIDTH]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wstate_q <= StIdle;
        else        wstate_q <= wstate_d;
    end

    // A pending error word owns the write port, so a START arriving that cycle is lost.
    always_comb begin
        wstate_d = wstate_q;
        if (rx_vld) begin
            unique case (wstate_q)
                StIdle, StDiscard: begin
                    if (is_start && !err_wr) begin
                        wstate_d = no_space ? StDiscard : (is_term ? StIdle : StInFrame);
                    end else if (is_term) begin
                        wstate_d = StIdle;
                    end
                end
                StInFrame: begin
                    if (is_start) begin
                        wstate_d = (STORE_FWD && rewind_ok) ? (is_term ? StIdle : StInFrame)
                                                            : StDiscard;
                    end else if (no_space) begin
                        wstate_d = StDiscard;
                    end else if (is_term) begin
                        wstate_d = StIdle;
                    end
                end
                default: wstate_d = StIdle;
            endcase
        end
    end

    always_comb begin
        we         = 1'b0;
        waddr      = wptr_q[AW-1:0];
        wdata      = {rx_c, rx_d};
        wptr_d     = wptr_q;
        cptr_d     = cptr_q;
        drop_inc   = 1'b0;
        err_pend_d = err_pend_q;
        if (err_wr) begin
            we         = 1'b1;
            wdata      = {ALL_C, ERR_D};
            wptr_d     = wptr_q + 1'b1;
            err_pend_d = 1'b0;
        end
        if (rx_vld) begin
            unique case (wstate_q)
                StIdle, StDiscard: begin
                    if (is_start && !err_wr) begin
                        if (no_space) begin
                            drop_inc = 1'b1;
                        end else begin
                            we     = 1'b1;
                            wptr_d = wptr_q + 1'b1;
                            if (STORE_FWD && is_term) cptr_d = wptr_q + 1'b1;
                        end
                    end
                end
                StInFrame: begin
                    if (is_start) begin
                        drop_inc = 1'b1;
                        if (STORE_FWD) begin
                            // Rewind and reuse the uncommitted space for the new frame.
                            wptr_d = cptr_q;
                            if (rewind_ok) begin
                                we     = 1'b1;
                                waddr  = cptr_q[AW-1:0];
                                wptr_d = cptr_q + 1'b1;
                                if (is_term) cptr_d = cptr_q + 1'b1;
                            end
                        end else if (!full) begin
                            we     = 1'b1;
                            wdata  = {ALL_C, ERR_D};
                            wptr_d = wptr_q + 1'b1;
                        end else begin
                            err_pend_d = 1'b1;
                        end
                    end else if (no_space) begin
                        drop_inc = 1'b1;
                        if (STORE_FWD) wptr_d = cptr_q;
                        else           err_pend_d = 1'b1;
                    end else begin
                        we     = 1'b1;
                        wptr_d = wptr_q + 1'b1;
                        if (STORE_FWD && is_term) cptr_d = wptr_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
        level_d = wptr_d - rptr_d;
    end

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            cptr_q     <= '0;
            level      <= '0;
            err_pend_q <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cptr_q     <= cptr_d;
            level      <= level_d;
            err_pend_q <= err_pend_d;
            if (drop_inc && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_d         <= IDLE_D;
            tx_c         <= ALL_C;
            rd_inframe_q <= 1'b0;
            unf_cnt      <= '0;
        end else if (tx_rdy) begin
            if (readable) begin
                {tx_c, tx_d} <= rd_word;
                if (rd_term)       rd_inframe_q <= 1'b0;
                else if (rd_start) rd_inframe_q <= 1'b1;
            end else if (!STORE_FWD && rd_inframe_q) begin
                tx_d <= UNF_D;
                tx_c <= ALL_C;
                if (unf_cnt != 16'hFFFF) unf_cnt <= unf_cnt + 16'd1;
            end else begin
                tx_d <= IDLE_D;
                tx_c <= ALL_C;
            end
        end
    end

endmodule

// File: tb/tb_xgmii_frame_fifo.sv
// Scoreboard bench: three FIFO flavours (32b SF, 64b SF depth 16, 32b CT depth 16); idle words
// on tx are filler and skipped by the monitors, every other word must match the queue head.
module tb_xgmii_frame_fifo;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  c;
    } word_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [31:0] rxd_a, txd_a;
    logic [3:0]  rxc_a, txc_a;
    logic        vld_a, rdy_a;
    logic [6:0]  lvl_a;
    logic [15:0] drop_a, unf_a;

    logic [63:0] rxd_b, txd_b;
    logic [7:0]  rxc_b, txc_b;
    logic        vld_b, rdy_b;
    logic [4:0]  lvl_b;
    logic [15:0] drop_b, unf_b;

    logic [31:0] rxd_c, txd_c;
    logic [3:0]  rxc_c, txc_c;
    logic        vld_c, rdy_c;
    logic [4:0]  lvl_c;
    logic [15:0] drop_c, unf_c;

    xgmii_frame_fifo #(.WIDTH(32), .DEPTH(64), .STORE_FWD(1'b1)) u_sf32 (
        .clk(clk), .rst_n(rst_n), .rx_d(rxd_a), .rx_c(rxc_a), .rx_vld(vld_a),
        .tx_d(txd_a), .tx_c(txc_a), .tx_rdy(rdy_a), .level(lvl_a),
        .drop_cnt(drop_a), .unf_cnt(unf_a));

    xgmii_frame_fifo #(.WIDTH(64), .DEPTH(16), .STORE_FWD(1'b1)) u_sf64 (
        .clk(clk), .rst_n(rst_n), .rx_d(rxd_b), .rx_c(rxc_b), .rx_vld(vld_b),
        .tx_d(txd_b), .tx_c(txc_b), .tx_rdy(rdy_b), .level(lvl_b),
        .drop_cnt(drop_b), .unf_cnt(unf_b));

    xgmii_frame_fifo #(.WIDTH(32), .DEPTH(16), .STORE_FWD(1'b0)) u_ct32 (
        .clk(clk), .rst_n(rst_n), .rx_d(rxd_c), .rx_c(rxc_c), .rx_vld(vld_c),
        .tx_d(txd_c), .tx_c(txc_c), .tx_rdy(rdy_c), .level(lvl_c),
        .drop_cnt(drop_c), .unf_cnt(unf_c));

    word_t q_a[$], q_b[$], q_c[$];
    int    checks = 0;
    int    errors = 0;
    bit    mon_off = 1'b0;
    bit    ra, rb, rc;

    localparam logic [71:0] IDLE32 = 72'({4'hF, 32'h07070707});

    function automatic logic [71:0] lo(word_t w);
        return 72'({w.c[3:0], w.d[31:0]});
    endfunction

    task automatic chk(input string name, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] dw(int seed, int i);
        return {8'(seed), 8'(i), 8'hA5, 8'(3 * i), 8'(seed + i), 8'h3C, 8'(seed ^ i), 8'(i + 1)};
    endfunction

    // i-th word of an n-word frame: START in lane0, TERM in lane1 on the last word.
    function automatic word_t mk(int seed, int i, int n);
        word_t w;
        w.d = dw(seed, i);
        w.c = 8'h00;
        if (i == 0) begin
            w.d[7:0] = 8'hFB;
            w.c      = 8'h01;
        end else if (i == n - 1) begin
            w.d[63:8] = {48'h070707070707, 8'hFD};
            w.c       = 8'hFE;
        end
        return w;
    endfunction

    function automatic word_t cw(logic [63:0] d);
        word_t w;
        w.d = d;
        w.c = 8'hFF;
        return w;
    endfunction

    task automatic push(int inst, word_t w);
        case (inst)
            0:       q_a.push_back(w);
            1:       q_b.push_back(w);
            default: q_c.push_back(w);
        endcase
    endtask

    task automatic drive(int inst, word_t w, bit vld);
        vld_a = 1'b0;
        vld_b = 1'b0;
        vld_c = 1'b0;
        case (inst)
            0:       begin rxd_a = w.d[31:0]; rxc_a = w.c[3:0]; vld_a = vld; end
            1:       begin rxd_b = w.d;       rxc_b = w.c;      vld_b = vld; end
            default: begin rxd_c = w.d[31:0]; rxc_c = w.c[3:0]; vld_c = vld; end
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        vld_a = 1'b0;
        vld_b = 1'b0;
        vld_c = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(int inst, int seed, int n, bit exp_out);
        for (int i = 0; i < n; i++) begin
            word_t w;
            w = mk(seed, i, n);
            if (exp_out) push(inst, w);
            drive(inst, w, 1'b1);
        end
    endtask

    task automatic mon(int inst, logic [63:0] d, logic [7:0] c);
        word_t e;
        bit    empty;
        logic [71:0] got, exp;
        if (inst == 1) begin
            if (d == 64'h0707070707070707 && c == 8'hFF) return;
            got = {c, d};
        end else begin
            if (d[31:0] == 32'h07070707 && c[3:0] == 4'hF) return;
            got = 72'({c[3:0], d[31:0]});
        end
        case (inst)
            0:       empty = (q_a.size() == 0);
            1:       empty = (q_b.size() == 0);
            default: empty = (q_c.size() == 0);
        endcase
        checks++;
        if (empty) begin
            errors++;
            $display("FAIL tx_word inst%0d: got %h expected no word", inst, got);
            return;
        end
        case (inst)
            0:       e = q_a.pop_front();
            1:       e = q_b.pop_front();
            default: e = q_c.pop_front();
        endcase
        exp = (inst == 1) ? {e.c, e.d} : lo(e);
        if (got !== exp) begin
            errors++;
            $display("FAIL tx_word inst%0d: got %h expected %h", inst, got, exp);
        end
    endtask

    always @(posedge clk) begin
        ra = rdy_a;
        #1;
        if (!mon_off && rst_n && ra) mon(0, {32'h0, txd_a}, {4'h0, txc_a});
    end
    always @(posedge clk) begin
        rb = rdy_b;
        #1;
        if (!mon_off && rst_n && rb) mon(1, txd_b, txc_b);
    end
    always @(posedge clk) begin
        rc = rdy_c;
        #1;
        if (!mon_off && rst_n && rc) mon(2, {32'h0, txd_c}, {4'h0, txc_c});
    end

    initial begin
        word_t w, fe, err, in_idle, l2;
        fe      = cw(64'hFEFEFEFEFEFEFEFE);
        err     = cw(64'h070707070707FDFE);
        in_idle = cw(64'h0707070707070707);

        rst_n = 1'b0;
        {rdy_a, rdy_b, rdy_c, vld_a, vld_b, vld_c} = '0;
        rxd_a = '0; rxc_a = '0; rxd_b = '0; rxc_b = '0; rxd_c = '0; rxc_c = '0;
        #23;
        chk("rst_tx_a", 72'({txc_a, txd_a}), IDLE32);
        chk("rst_tx_b", 72'({txc_b, txd_b}), {8'hFF, 64'h0707070707070707});
        chk("rst_lvl_a", 72'(lvl_a), 72'd0);
        chk("rst_cnt_c", 72'({drop_c, unf_c}), 72'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 32b store-and-forward: latency after TERM, input idles stripped.
        rdy_a = 1'b1;
        idle(3);
        send_frame(0, 1, 16, 1'b1);
        chk("sf_lvl_at_term", 72'(lvl_a), 72'd16);
        chk("sf_tx_before_start", 72'({txc_a, txd_a}), IDLE32);
        drive(0, in_idle, 1'b1);
        chk("sf_start_latency", 72'({txc_a, txd_a}), lo(mk(1, 0, 16)));
        drive(0, in_idle, 1'b1);
        drive(0, in_idle, 1'b1);
        send_frame(0, 2, 10, 1'b1);
        chk("sf_lvl_idles_removed", 72'(lvl_a), 72'd13);
        idle(30);

        // 64b store-and-forward, depth 16: oversize frame dropped, next frame intact.
        rdy_b = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(1, mk(3, i, 20), 1'b1);
            if (i == 15) chk("sf64_lvl_full", 72'(lvl_b), 72'd16);
            if (i == 16) chk("sf64_rewind", 72'({drop_b, 3'b000, lvl_b}), 72'({16'd1, 8'd0}));
        end
        idle(2);
        send_frame(1, 4, 8, 1'b1);
        idle(15);
        chk("sf64_drop_cnt", 72'(drop_b), 72'd1);

        // Cut-through, consumer stalled: 16 words then error-terminate.
        for (int i = 0; i < 24; i++) begin
            w = mk(5, i, 24);
            if (i < 16) push(2, w);
            drive(2, w, 1'b1);
        end
        push(2, err);
        chk("ct_lvl_full", 72'(lvl_c), 72'd16);
        chk("ct_drop_cnt", 72'(drop_c), 72'd1);
        chk("ct_hold_idle", 72'({txc_c, txd_c}), IDLE32);
        rdy_c = 1'b1;
        idle(25);

        // Cut-through with rx_vld toggling: underrun fill between words.
        for (int i = 0; i < 6; i++) begin
            w = mk(6, i, 6);
            push(2, w);
            if (i < 5) push(2, fe);
            drive(2, w, 1'b1);
            if (i == 0) chk("ct_tx_before", 72'({txc_c, txd_c}), IDLE32);
            if (i < 5) begin
                drive(2, w, 1'b0);
                if (i == 0) chk("ct_latency", 72'({txc_c, txd_c}), lo(w));
            end
        end
        idle(5);
        chk("ct_unf_cnt", 72'(unf_c), 72'd5);

        // Lane-2 START ignored, then START while in frame (SF on inst 0, CT on inst 2).
        for (int inst = 0; inst < 3; inst += 2) begin
            l2.d        = dw(7, 0);
            l2.d[23:16] = 8'hFB;
            l2.c        = 8'h04;
            drive(inst, l2, 1'b1);
            for (int i = 1; i < 3; i++) drive(inst, mk(7, i, 10), 1'b1);
            for (int i = 0; i < 3; i++) begin
                w = mk(8, i, 10);
                if (inst == 2) push(inst, w);
                drive(inst, w, 1'b1);
            end
            if (inst == 2) push(inst, err);
            for (int i = 0; i < 4; i++) begin
                w = mk(9, i, 4);
                if (inst == 0) push(inst, w);
                drive(inst, w, 1'b1);
            end
            idle(10);
        end
        chk("restart_drop_sf", 72'(drop_a), 72'd1);
        chk("restart_drop_ct", 72'(drop_c), 72'd2);
        chk("restart_unf_ct", 72'(unf_c), 72'd5);
        idle(10);
        chk("q_a_drained", 72'(q_a.size()), 72'd0);
        chk("q_b_drained", 72'(q_b.size()), 72'd0);
        chk("q_c_drained", 72'(q_c.size()), 72'd0);

        // Asynchronous reset mid-frame.
        mon_off = 1'b1;
        for (int i = 0; i < 3; i++) drive(2, mk(10, i, 8), 1'b1);
        chk("pre_rst_tx", 72'({txc_c, txd_c}), lo(mk(10, 1, 8)));
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_async_tx", 72'({txc_c, txd_c}), IDLE32);
        chk("rst_async_lvl", 72'(lvl_c), 72'd0);
        chk("rst_async_cnt", 72'({drop_c, unf_c}), 72'd0);
        chk("rst_async_drop_b", 72'(drop_b), 72'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 3; i < 8; i++) drive(2, mk(10, i, 8), 1'b1);
        chk("post_rst_tail_dropped", 72'({txc_c, txd_c, 3'b000, lvl_c}), {IDLE32[63:0], 8'd0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
